// File: rtl/ne_bus_responder_if.sv
// CPU-side bus and NIC-side strobe signals of the NE bus responder.
// master: the CPU/NIC environment; slave: the responder itself.
interface ne_bus_responder_if;
  logic AS_n;       // CPU address strobe, asynchronous, active-low
  logic CE_n;       // registered chip-enable from the address decoder, active-low
  logic RW;         // 1 = read
  logic IORDY;      // NIC ready, 1 = ready
  logic IOR_n;      // NIC read strobe
  logic IOW_n;      // NIC write strobe
  logic DBUF_OE_n;  // data buffer enable
  logic DBUF_DIR;   // 1 = NIC to CPU
  logic DTACK_n;    // CPU transfer acknowledge
  logic BERR_n;     // CPU bus error

  modport master (
    output AS_n, CE_n, RW, IORDY,
    input  IOR_n, IOW_n, DBUF_OE_n, DBUF_DIR, DTACK_n, BERR_n
  );

  modport slave (
    input  AS_n, CE_n, RW, IORDY,
    output IOR_n, IOW_n, DBUF_OE_n, DBUF_DIR, DTACK_n, BERR_n
  );
endinterface

// File: rtl/ne_bus_responder.sv
// Bridges an asynchronous CPU bus cycle onto the NIC read/write strobes:
// setup delay, minimum strobe width, IORDY wait with timeout to bus error.
// Every output is a flop; next-output values are decoded from the next state.
module ne_bus_responder #(
  parameter int unsigned SETUP_CYC   = 1,    // 1..15
  parameter int unsigned STROBE_CYC  = 4,    // 1..15
  parameter int unsigned TIMEOUT_CYC = 255   // 1..255
) (
  input logic               CLK,
  input logic               RESET,
  ne_bus_responder_if.slave io_bus
);

  localparam logic [3:0] SetupLast   = 4'(SETUP_CYC - 1);
  localparam logic [3:0] StrobeLast  = 4'(STROBE_CYC - 1);
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStrobe,
    StWaitRdy,
    StAck,
    StErr
  } state_e;

  state_e     r_state, w_state_d;

  logic       r_as_meta, r_as_s;
  logic [1:0] r_sync_vld;
  logic       r_armed, w_armed_d;
  logic       r_rw, w_rw_d;
  logic [3:0] r_cnt, w_cnt_d;
  logic [7:0] r_wcnt, w_wcnt_d;
  logic       w_start;

  logic       r_ior_n, w_ior_n_d;
  logic       r_iow_n, w_iow_n_d;
  logic       r_oe_n, w_oe_n_d;
  logic       r_dir, w_dir_d;
  logic       r_dtack_n, w_dtack_n_d;
  logic       r_berr_n, w_berr_n_d;

  // Two-flop synchronizer for AS_n; r_sync_vld marks when r_as_s carries a
  // real sample rather than the reset value.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_as_meta  <= 1'b1;
      r_as_s     <= 1'b1;
      r_sync_vld <= 2'b00;
    end else begin
      r_as_meta  <= io_bus.AS_n;
      r_as_s     <= r_as_meta;
      r_sync_vld <= {r_sync_vld[0], 1'b1};
    end
  end

  // A cycle may only start once a genuine negated AS_n has been seen since the
  // last start, so a reset released mid-cycle does not pick up a stale strobe.
  always_comb begin
    w_start   = (r_state == StIdle) && !io_bus.CE_n && !r_as_s && r_armed;
    w_armed_d = r_armed;
    if (w_start) begin
      w_armed_d = 1'b0;
    end else if (r_as_s && r_sync_vld[1]) begin
      w_armed_d = 1'b1;
    end
    w_rw_d = w_start ? io_bus.RW : r_rw;
  end

  // State register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state decode; a negated AS_n always wins over everything else, and
  // IORDY wins over the timeout on the same edge.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_start) w_state_d = StSetup;
      end
      StSetup: begin
        if (r_as_s)                  w_state_d = StIdle;
        else if (r_cnt >= SetupLast) w_state_d = StStrobe;
      end
      StStrobe: begin
        if (r_as_s)                   w_state_d = StIdle;
        else if (r_cnt >= StrobeLast) w_state_d = io_bus.IORDY ? StAck : StWaitRdy;
      end
      StWaitRdy: begin
        if (r_as_s)                     w_state_d = StIdle;
        else if (io_bus.IORDY)          w_state_d = StAck;
        else if (r_wcnt >= TimeoutLast) w_state_d = StErr;
      end
      StAck, StErr: begin
        if (r_as_s) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Phase counter restarts on every state change; wait counter restarts on
  // STROBE entry and only advances while waiting. Both saturate.
  always_comb begin
    w_cnt_d = r_cnt;
    if (w_state_d != r_state) begin
      w_cnt_d = '0;
    end else if ((r_state == StSetup || r_state == StStrobe) && r_cnt != 4'hF) begin
      w_cnt_d = r_cnt + 4'd1;
    end

    w_wcnt_d = r_wcnt;
    if (w_state_d == StStrobe && r_state != StStrobe) begin
      w_wcnt_d = '0;
    end else if (r_state == StWaitRdy && w_state_d == StWaitRdy && r_wcnt != 8'hFF) begin
      w_wcnt_d = r_wcnt + 8'd1;
    end
  end

  // Counter and latched-direction registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_cnt   <= '0;
      r_wcnt  <= '0;
      r_rw    <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_d;
      r_wcnt  <= w_wcnt_d;
      r_rw    <= w_rw_d;
      r_armed <= w_armed_d;
    end
  end

  // Output decode from the next state so registered outputs change on the
  // same edge as the state they belong to.
  always_comb begin
    w_ior_n_d   = 1'b1;
    w_iow_n_d   = 1'b1;
    w_oe_n_d    = 1'b1;
    w_dir_d     = 1'b0;
    w_dtack_n_d = 1'b1;
    w_berr_n_d  = 1'b1;
    unique case (w_state_d)
      StSetup: begin
        w_oe_n_d = 1'b0;
        w_dir_d  = w_rw_d;
      end
      StStrobe, StWaitRdy: begin
        w_oe_n_d  = 1'b0;
        w_dir_d   = w_rw_d;
        w_ior_n_d = !w_rw_d;
        w_iow_n_d = w_rw_d;
      end
      StAck: begin
        // Read strobe stays low so the NIC keeps driving the data.
        w_oe_n_d    = 1'b0;
        w_dir_d     = w_rw_d;
        w_ior_n_d   = !w_rw_d;
        w_dtack_n_d = 1'b0;
      end
      StErr: begin
        w_berr_n_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Output registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_ior_n   <= 1'b1;
      r_iow_n   <= 1'b1;
      r_oe_n    <= 1'b1;
      r_dir     <= 1'b0;
      r_dtack_n <= 1'b1;
      r_berr_n  <= 1'b1;
    end else begin
      r_ior_n   <= w_ior_n_d;
      r_iow_n   <= w_iow_n_d;
      r_oe_n    <= w_oe_n_d;
      r_dir     <= w_dir_d;
      r_dtack_n <= w_dtack_n_d;
      r_berr_n  <= w_berr_n_d;
    end
  end

  assign io_bus.IOR_n     = r_ior_n;
  assign io_bus.IOW_n     = r_iow_n;
  assign io_bus.DBUF_OE_n = r_oe_n;
  assign io_bus.DBUF_DIR  = r_dir;
  assign io_bus.DTACK_n   = r_dtack_n;
  assign io_bus.BERR_n    = r_berr_n;

  // Acknowledge and error, and the two strobes, are mutually exclusive.
  a_ack_err_excl: assert property (@(posedge CLK) disable iff (!RESET)
    (r_dtack_n || r_berr_n));
  a_strobe_excl: assert property (@(posedge CLK) disable iff (!RESET)
    (r_ior_n || r_iow_n));

endmodule

// File: tb/tb_ne_bus_responder.sv
// Directed bench for ne_bus_responder: a timeline model predicts every output
// on every cycle, and literal expectations pin key edges of each scenario.
module tb_ne_bus_responder;

  localparam int unsigned SETUP   = 1;
  localparam int unsigned STROBE  = 4;
  localparam int unsigned TIMEOUT = 8;

  logic CLK = 1'b0;
  logic RESET;

  ne_bus_responder_if u_bus ();

  ne_bus_responder #(
    .SETUP_CYC  (SETUP),
    .STROBE_CYC (STROBE),
    .TIMEOUT_CYC(TIMEOUT)
  ) u_dut (
    .CLK   (CLK),
    .RESET (RESET),
    .io_bus(u_bus)
  );

  always #5 CLK = ~CLK;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic chk(input string name, input logic got, input logic exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b, required %b", name, got, exp);
  endtask

  // ---------------- timeline model ----------------
  // A bus cycle is described by its start edge; its phase is plain arithmetic
  // on the edges elapsed since then.
  bit m_busy  = 1'b0;
  bit m_done  = 1'b0;
  bit m_err   = 1'b0;
  bit m_rw    = 1'b0;
  bit m_armed = 1'b0;
  int m_edge  = 0;
  int m_t0    = 0;
  bit as_hist[$];

  logic e_ior_n = 1'b1, e_iow_n = 1'b1, e_oe_n = 1'b1, e_dir = 1'b0;
  logic e_dtack_n = 1'b1, e_berr_n = 1'b1;

  initial begin : model
    bit as_s;
    bit real_s;
    int k;
    forever begin
      @(posedge CLK or negedge RESET);
      if (!RESET) begin
        m_busy  = 1'b0;
        m_done  = 1'b0;
        m_err   = 1'b0;
        m_armed = 1'b0;
        as_hist.delete();
      end else begin
        m_edge++;
        // as_s seen at this edge is AS_n from two edges ago, if both were after reset.
        real_s = (as_hist.size() == 2);
        as_s   = real_s ? as_hist[0] : 1'b1;
        if (!m_busy) begin
          if (!u_bus.CE_n && real_s && !as_s && m_armed) begin
            m_busy  = 1'b1;
            m_done  = 1'b0;
            m_err   = 1'b0;
            m_t0    = m_edge;
            m_rw    = u_bus.RW;
            m_armed = 1'b0;
          end else if (real_s && as_s) begin
            m_armed = 1'b1;
          end
        end else if (as_s) begin
          m_busy  = 1'b0;
          m_armed = 1'b1;
        end else if (!m_done) begin
          k = m_edge - m_t0;
          if (k >= int'(SETUP + STROBE)) begin
            if (u_bus.IORDY) begin
              m_done = 1'b1;
              m_err  = 1'b0;
            end else if (k >= int'(SETUP + STROBE + TIMEOUT)) begin
              m_done = 1'b1;
              m_err  = 1'b1;
            end
          end
        end
        as_hist.push_back(u_bus.AS_n);
        if (as_hist.size() > 2) void'(as_hist.pop_front());
      end
      e_ior_n = 1'b1; e_iow_n = 1'b1; e_oe_n = 1'b1; e_dir = 1'b0;
      e_dtack_n = 1'b1; e_berr_n = 1'b1;
      if (m_busy) begin
        if (m_done && m_err) begin
          e_berr_n = 1'b0;
        end else if (m_done) begin
          e_oe_n = 1'b0; e_dir = m_rw; e_ior_n = !m_rw; e_dtack_n = 1'b0;
        end else if (m_edge - m_t0 < int'(SETUP)) begin
          e_oe_n = 1'b0; e_dir = m_rw;
        end else begin
          e_oe_n = 1'b0; e_dir = m_rw; e_ior_n = !m_rw; e_iow_n = m_rw;
        end
      end
    end
  end

  // Compare every cycle, away from the active edge.
  initial begin : compare
    forever begin
      @(negedge CLK);
      chk($sformatf("e%0d IOR_n", m_edge),     u_bus.IOR_n,     e_ior_n);
      chk($sformatf("e%0d IOW_n", m_edge),     u_bus.IOW_n,     e_iow_n);
      chk($sformatf("e%0d DBUF_OE_n", m_edge), u_bus.DBUF_OE_n, e_oe_n);
      chk($sformatf("e%0d DBUF_DIR", m_edge),  u_bus.DBUF_DIR,  e_dir);
      chk($sformatf("e%0d DTACK_n", m_edge),   u_bus.DTACK_n,   e_dtack_n);
      chk($sformatf("e%0d BERR_n", m_edge),    u_bus.BERR_n,    e_berr_n);
      chk($sformatf("e%0d strobe excl", m_edge), u_bus.IOR_n | u_bus.IOW_n, 1'b1);
      chk($sformatf("e%0d ack/err excl", m_edge), u_bus.DTACK_n | u_bus.BERR_n, 1'b1);
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: bench did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Returns at the negedge after edge 0 (the edge that accepts the cycle).
  task automatic start_cycle(input logic rw, input logic rdy);
    u_bus.AS_n  = 1'b0;
    u_bus.CE_n  = 1'b0;
    u_bus.RW    = rw;
    u_bus.IORDY = rdy;
    step(3);
  endtask

  task automatic end_cycle();
    u_bus.AS_n = 1'b1;
    u_bus.CE_n = 1'b1;
    step(3);
  endtask

  initial begin : stim
    RESET       = 1'b0;
    u_bus.AS_n  = 1'b1;
    u_bus.CE_n  = 1'b1;
    u_bus.RW    = 1'b0;
    u_bus.IORDY = 1'b1;
    step(2);
    chk("reset IOR_n", u_bus.IOR_n, 1'b1);
    chk("reset DBUF_OE_n", u_bus.DBUF_OE_n, 1'b1);
    chk("reset DBUF_DIR", u_bus.DBUF_DIR, 1'b0);
    chk("reset DTACK_n", u_bus.DTACK_n, 1'b1);
    RESET = 1'b1;
    step(5);

    // Read, IORDY=1; CE_n kept low in ACK must not restart anything.
    start_cycle(1'b1, 1'b1);
    chk("rd e0 DBUF_OE_n", u_bus.DBUF_OE_n, 1'b0);
    chk("rd e0 DBUF_DIR", u_bus.DBUF_DIR, 1'b1);
    chk("rd e0 IOR_n", u_bus.IOR_n, 1'b1);
    step(1);
    chk("rd e1 IOR_n", u_bus.IOR_n, 1'b0);
    step(3);
    chk("rd e4 DTACK_n", u_bus.DTACK_n, 1'b1);
    step(1);
    chk("rd e5 DTACK_n", u_bus.DTACK_n, 1'b0);
    chk("rd e5 IOR_n", u_bus.IOR_n, 1'b0);
    step(3);
    chk("rd e8 DTACK_n held", u_bus.DTACK_n, 1'b0);
    u_bus.AS_n = 1'b1;
    u_bus.CE_n = 1'b1;
    step(2);
    chk("rd as_s=1 DTACK_n", u_bus.DTACK_n, 1'b0);
    step(1);
    chk("rd exit DTACK_n", u_bus.DTACK_n, 1'b1);
    chk("rd exit IOR_n", u_bus.IOR_n, 1'b1);
    chk("rd exit DBUF_DIR", u_bus.DBUF_DIR, 1'b0);
    step(2);

    // Write, IORDY=1.
    start_cycle(1'b0, 1'b1);
    chk("wr e0 DBUF_DIR", u_bus.DBUF_DIR, 1'b0);
    chk("wr e0 IOW_n", u_bus.IOW_n, 1'b1);
    step(1);
    chk("wr e1 IOW_n", u_bus.IOW_n, 1'b0);
    step(3);
    chk("wr e4 IOW_n", u_bus.IOW_n, 1'b0);
    step(1);
    chk("wr e5 IOW_n", u_bus.IOW_n, 1'b1);
    chk("wr e5 DTACK_n", u_bus.DTACK_n, 1'b0);
    chk("wr e5 DBUF_DIR", u_bus.DBUF_DIR, 1'b0);
    end_cycle();
    chk("wr exit DTACK_n", u_bus.DTACK_n, 1'b1);
    step(2);

    // Read, IORDY low until after edge 9.
    start_cycle(1'b1, 1'b0);
    step(5);
    chk("wait e5 DTACK_n", u_bus.DTACK_n, 1'b1);
    chk("wait e5 IOR_n", u_bus.IOR_n, 1'b0);
    step(4);
    chk("wait e9 DTACK_n", u_bus.DTACK_n, 1'b1);
    u_bus.IORDY = 1'b1;
    step(1);
    chk("wait e10 DTACK_n", u_bus.DTACK_n, 1'b0);
    chk("wait e10 IOR_n", u_bus.IOR_n, 1'b0);
    end_cycle();
    step(2);

    // Write, IORDY stuck low: bus error at edge 13.
    start_cycle(1'b0, 1'b0);
    step(12);
    chk("to e12 BERR_n", u_bus.BERR_n, 1'b1);
    chk("to e12 IOW_n", u_bus.IOW_n, 1'b0);
    step(1);
    chk("to e13 BERR_n", u_bus.BERR_n, 1'b0);
    chk("to e13 DTACK_n", u_bus.DTACK_n, 1'b1);
    chk("to e13 IOW_n", u_bus.IOW_n, 1'b1);
    chk("to e13 DBUF_OE_n", u_bus.DBUF_OE_n, 1'b1);
    step(2);
    chk("to e15 BERR_n", u_bus.BERR_n, 1'b0);
    end_cycle();
    chk("to exit BERR_n", u_bus.BERR_n, 1'b1);
    step(2);

    // IORDY rises exactly on the timeout edge: ready wins.
    start_cycle(1'b1, 1'b0);
    step(12);
    u_bus.IORDY = 1'b1;
    step(1);
    chk("rw e13 DTACK_n", u_bus.DTACK_n, 1'b0);
    chk("rw e13 BERR_n", u_bus.BERR_n, 1'b1);
    end_cycle();
    step(2);

    // Abort: as_s rises at edge 3 of a read, then a clean cycle follows.
    start_cycle(1'b1, 1'b1);
    step(1);
    u_bus.AS_n = 1'b1;
    u_bus.CE_n = 1'b1;
    step(2);
    chk("ab e3 IOR_n", u_bus.IOR_n, 1'b0);
    step(1);
    chk("ab e4 IOR_n", u_bus.IOR_n, 1'b1);
    chk("ab e4 DBUF_OE_n", u_bus.DBUF_OE_n, 1'b1);
    step(3);
    chk("ab e7 DTACK_n", u_bus.DTACK_n, 1'b1);
    start_cycle(1'b1, 1'b1);
    chk("ab2 e0 DBUF_OE_n", u_bus.DBUF_OE_n, 1'b0);
    step(5);
    chk("ab2 e5 DTACK_n", u_bus.DTACK_n, 1'b0);
    end_cycle();
    step(2);

    // Reset in WAITRDY, released with AS_n still low.
    start_cycle(1'b1, 1'b0);
    step(7);
    chk("rst pre IOR_n", u_bus.IOR_n, 1'b0);
    #2 RESET = 1'b0;
    #1;
    chk("rst async IOR_n", u_bus.IOR_n, 1'b1);
    chk("rst async DBUF_OE_n", u_bus.DBUF_OE_n, 1'b1);
    chk("rst async DBUF_DIR", u_bus.DBUF_DIR, 1'b0);
    step(2);
    RESET       = 1'b1;
    u_bus.IORDY = 1'b1;
    step(8);
    chk("rst held DBUF_OE_n", u_bus.DBUF_OE_n, 1'b1);
    chk("rst held IOR_n", u_bus.IOR_n, 1'b1);
    u_bus.AS_n = 1'b1;
    step(3);
    start_cycle(1'b1, 1'b1);
    chk("rst new e0 DBUF_OE_n", u_bus.DBUF_OE_n, 1'b0);
    step(5);
    chk("rst new e5 DTACK_n", u_bus.DTACK_n, 1'b0);
    end_cycle();
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
